// File: rtl/pred_ctx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pred_ctx_pkg
// Description : Context word layout, NOP constant, mux/demux encodings and
//               sequencer state type for the predicate context sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pred_ctx_pkg;

    localparam int IN_P_W    = 9;
    localparam int PUT_IN_W  = 6;
    localparam int PUT_OUT_W = 6;
    localparam int WB_W      = 1;
    localparam int PRED_W    = 6;
    localparam int SEND_W    = 6;
    localparam int OUT_P_W   = 9;
    localparam int PE2FU_W   = 4;

    localparam int PE2FU_LSB   = 0;
    localparam int OUT_P_LSB   = PE2FU_LSB   + PE2FU_W;
    localparam int SEND_LSB    = OUT_P_LSB   + OUT_P_W;
    localparam int PRED_LSB    = SEND_LSB    + SEND_W;
    localparam int WB_LSB      = PRED_LSB    + PRED_W;
    localparam int PUT_OUT_LSB = WB_LSB      + WB_W;
    localparam int PUT_IN_LSB  = PUT_OUT_LSB + PUT_OUT_W;
    localparam int IN_P_LSB    = PUT_IN_LSB  + PUT_IN_W;
    localparam int CTX_BITS    = IN_P_LSB    + IN_P_W;

    typedef struct packed {
        logic [IN_P_W-1:0]    in_p;
        logic [PUT_IN_W-1:0]  put_in;
        logic [PUT_OUT_W-1:0] put_out;
        logic [WB_W-1:0]      wb;
        logic [PRED_W-1:0]    pred;
        logic [SEND_W-1:0]    send;
        logic [OUT_P_W-1:0]   out_p;
        logic [PE2FU_W-1:0]   pe2fu;
    } ctx_t;

    // All-zero context: no write-back, every write lands in null entry 0.
    localparam ctx_t CTX_NOP = '0;

    localparam logic [8:0] IN_EDGE2    = 9'h004;
    localparam logic [8:0] IN_EDGE5    = 9'h002;
    localparam logic [8:0] IN_BUS      = 9'h010;
    localparam logic [3:0] PE2FU_EDGE2 = 4'b0011;
    localparam logic [3:0] PE2FU_EDGE5 = 4'b0010;
    localparam logic [3:0] PE2FU_BUS   = 4'b1000;
    localparam logic [3:0] PE2FU_REG   = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic ctx_t ctx_unpack(input logic [CTX_BITS-1:0] w);
        ctx_t c;
        c.in_p    = w[IN_P_LSB    +: IN_P_W];
        c.put_in  = w[PUT_IN_LSB  +: PUT_IN_W];
        c.put_out = w[PUT_OUT_LSB +: PUT_OUT_W];
        c.wb      = w[WB_LSB      +: WB_W];
        c.pred    = w[PRED_LSB    +: PRED_W];
        c.send    = w[SEND_LSB    +: SEND_W];
        c.out_p   = w[OUT_P_LSB   +: OUT_P_W];
        c.pe2fu   = w[PE2FU_LSB   +: PE2FU_W];
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pred_ctx_sequencer_mem.sv
`default_nettype none
// ============================================================================
// Module      : pred_ctx_sequencer_mem
// Description : Context store, synchronous write / asynchronous read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pred_ctx_sequencer_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CTX_W = 47
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [CTX_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [CTX_W-1:0] o_rdata
);

    logic [CTX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pred_ctx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pred_ctx_sequencer
// Description : Steps a loaded context loop and registers the predicate
//               register-file controls for a programmed iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
module pred_ctx_sequencer
    import pred_ctx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int ITW   = 8,
    parameter int CTX_W = 47
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [CTX_W-1:0] cfg_data,
    input  logic             start,
    input  logic [AW-1:0]    ctx_last,
    input  logic [ITW-1:0]   iter_cnt,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic [8:0]       control_in_p,
    output logic [5:0]       control_put_in_p,
    output logic [5:0]       control_put_out_p,
    output logic             write_back_p,
    output logic [5:0]       control_pred,
    output logic [5:0]       control_send_p,
    output logic [8:0]       control_out_p,
    output logic [3:0]       control_pe2fu_p
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    r_last;
    logic [ITW-1:0]   r_rem;
    ctx_t             r_ctx;
    logic             r_done;
    logic [CTX_W-1:0] w_rdata;
    logic             w_cfg_wr;
    logic             w_launch;
    logic             w_issue;
    logic             w_wrap;
    logic             w_final;

    assign w_cfg_wr = cfg_we && (r_state == IDLE);
    assign w_launch = start && (r_state == IDLE);
    assign w_issue  = (r_state == RUN) && !stall;
    assign w_wrap   = (r_ptr == r_last);
    assign w_final  = w_issue && w_wrap && (r_rem == ITW'(1));

    pred_ctx_sequencer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CTX_W (CTX_W)
    ) u_mem (
        .clk     (CLK),
        .i_we    (w_cfg_wr),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr (r_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_state_nxt = RUN;
            RUN:     if (w_final)  w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are NOP in every cycle that does not issue a context.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr  <= '0;
            r_last <= '0;
            r_rem  <= '0;
            r_ctx  <= CTX_NOP;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            r_ctx  <= w_issue ? ctx_unpack(w_rdata) : CTX_NOP;
            if (w_launch) begin
                r_ptr  <= '0;
                r_last <= ctx_last;
                r_rem  <= (iter_cnt == '0) ? ITW'(1) : iter_cnt;
            end else if (w_issue) begin
                if (w_wrap) begin
                    r_ptr <= '0;
                    r_rem <= r_rem - ITW'(1);
                end else begin
                    r_ptr <= r_ptr + AW'(1);
                end
            end
        end
    end

    assign busy              = (r_state == RUN);
    assign done              = r_done;
    assign control_in_p      = r_ctx.in_p;
    assign control_put_in_p  = r_ctx.put_in;
    assign control_put_out_p = r_ctx.put_out;
    assign write_back_p      = r_ctx.wb;
    assign control_pred      = r_ctx.pred;
    assign control_send_p    = r_ctx.send;
    assign control_out_p     = r_ctx.out_p;
    assign control_pe2fu_p   = r_ctx.pe2fu;

endmodule
`default_nettype wire

// File: tb/tb_pred_ctx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pred_ctx_sequencer
// Description : Table vectors, corner sequences and randomized runs against a
//               queue-based reference model of the context sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pred_ctx_sequencer;
    import pred_ctx_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int ITW   = 8;
    localparam int CTX_W = 47;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b1;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [CTX_W-1:0] cfg_data = '0;
    logic             start = 1'b0;
    logic [AW-1:0]    ctx_last = '0;
    logic [ITW-1:0]   iter_cnt = '0;
    logic             stall = 1'b0;
    logic             busy, done, write_back_p;
    logic [8:0]       control_in_p, control_out_p;
    logic [5:0]       control_put_in_p, control_put_out_p, control_pred, control_send_p;
    logic [3:0]       control_pe2fu_p;

    always #5 CLK = ~CLK;

    pred_ctx_sequencer #(.DEPTH(DEPTH), .AW(AW), .ITW(ITW), .CTX_W(CTX_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .ctx_last(ctx_last),
        .iter_cnt(iter_cnt), .stall(stall), .busy(busy), .done(done),
        .control_in_p(control_in_p), .control_put_in_p(control_put_in_p),
        .control_put_out_p(control_put_out_p), .write_back_p(write_back_p),
        .control_pred(control_pred), .control_send_p(control_send_p),
        .control_out_p(control_out_p), .control_pe2fu_p(control_pe2fu_p)
    );

    int n_cmp = 0;
    int n_err = 0;
    int dut_issued = 0;

    function automatic logic [48:0] obs();
        return {busy, done, control_in_p, control_put_in_p, control_put_out_p,
                write_back_p, control_pred, control_send_p, control_out_p,
                control_pe2fu_p};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a start expands into the full list of context indices
    // to issue; each unstalled RUN cycle pops one.
    logic [CTX_W-1:0] mem_m [DEPTH];
    int               q[$];
    int               phase = 0;   // 0 idle, 1 run, 2 done
    logic [48:0]      exp_obs;

    task automatic model_edge();
        logic [CTX_W-1:0] o;
        logic             d;
        int               n;
        o = '0;
        d = 1'b0;
        case (phase)
            0: begin
                if (cfg_we) mem_m[cfg_addr] = cfg_data;
                if (start) begin
                    n = (iter_cnt == 0) ? 1 : int'(iter_cnt);
                    for (int it = 0; it < n; it++)
                        for (int c = 0; c <= int'(ctx_last); c++) q.push_back(c);
                    phase = 1;
                end
            end
            1: if (!stall) begin
                o = mem_m[q.pop_front()];
                if (q.size() == 0) phase = 2;
            end
            default: begin
                d = 1'b1;
                phase = 0;
            end
        endcase
        exp_obs = {(phase == 1), d, o};
    endtask

    task automatic step(input string name);
        model_edge();
        @(posedge CLK);
        #1;
        if (obs() & 49'h0_7FFF_FFFF_FFFF) dut_issued++;
        check(name, 64'(obs()), 64'(exp_obs));
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [CTX_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step("load_idle");
        cfg_we = 1'b0;
    endtask

    task automatic run_model(input int last, input int iter, input int stall_pct, input bit noise);
        int guard;
        ctx_last = AW'(last); iter_cnt = ITW'(iter); start = 1'b1;
        if (noise) begin
            cfg_we = 1'b1; cfg_addr = AW'(last); cfg_data = {$urandom, $urandom};
        end
        step("run_start");
        start = 1'b0; cfg_we = 1'b0;
        guard = 0;
        while (phase != 0 && guard < 400) begin
            stall = ($urandom_range(0, 99) < stall_pct);
            if (noise) begin
                cfg_we = $urandom_range(0, 3) == 0; cfg_addr = AW'($urandom);
                cfg_data = {$urandom, $urandom}; start = $urandom_range(0, 3) == 0;
            end
            step("run_cycle");
            stall = 1'b0; cfg_we = 1'b0; start = 1'b0;
            guard++;
        end
        if (guard >= 400) check("run_timeout", 64'(guard), 64'(0));
        step("run_after_done");
    endtask

    typedef struct {
        logic             start;
        logic             stall;
        logic [AW-1:0]    last;
        logic [ITW-1:0]   iter;
        logic             ebusy;
        logic             edone;
        logic [CTX_W-1:0] ectx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic st, input int l, input int it,
                                input logic eb, input logic ed, input logic [CTX_W-1:0] c);
        vec_t v;
        v.start = s; v.stall = st; v.last = AW'(l); v.iter = ITW'(it);
        v.ebusy = eb; v.edone = ed; v.ectx = c;
        return v;
    endfunction

    initial begin
        ctx_t c0, c1, c2;
        logic [CTX_W-1:0] k0, k1, k2, z;
        int n;
        z = '0;
        c0 = CTX_NOP; c0.put_in = 6'd5; c0.in_p = IN_EDGE2;
        c1 = CTX_NOP; c1.wb = 1'b1; c1.put_out = 6'd7;
        c2 = CTX_NOP; c2.send = 6'd5; c2.out_p = IN_EDGE2;
        k0 = c0; k1 = c1; k2 = c2;

        // Reset asserted mid-cycle must clear outputs without a clock edge.
        #12 RST_N = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_ctrl", 64'(obs()), 64'(0));
        @(posedge CLK); #1 RST_N = 1'b1;

        for (int a = 0; a < DEPTH; a++) load(AW'(a), '0);
        load(4'd0, k0); load(4'd1, k1); load(4'd2, k2);

        // Basic loop: II=3, two iterations
        tbl.push_back(mk(1, 0, 2, 2, 1, 0, z));
        tbl.push_back(mk(0, 0, 2, 2, 1, 0, k0));
        tbl.push_back(mk(0, 0, 2, 2, 1, 0, k1));
        tbl.push_back(mk(0, 0, 2, 2, 1, 0, k2));
        tbl.push_back(mk(0, 0, 2, 2, 1, 0, k0));
        tbl.push_back(mk(0, 0, 2, 2, 1, 0, k1));
        tbl.push_back(mk(0, 0, 2, 2, 0, 0, k2));
        tbl.push_back(mk(0, 0, 2, 2, 0, 1, z));
        tbl.push_back(mk(0, 0, 2, 2, 0, 0, z));
        // II=1 with iter_cnt=0 issues ctx0 exactly once
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, z));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, k0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, z));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, z));
        // Two stall cycles while ctx1 is pending
        tbl.push_back(mk(1, 0, 2, 1, 1, 0, z));
        tbl.push_back(mk(0, 0, 2, 1, 1, 0, k0));
        tbl.push_back(mk(0, 1, 2, 1, 1, 0, z));
        tbl.push_back(mk(0, 1, 2, 1, 1, 0, z));
        tbl.push_back(mk(0, 0, 2, 1, 1, 0, k1));
        tbl.push_back(mk(0, 0, 2, 1, 0, 0, k2));
        tbl.push_back(mk(0, 0, 2, 1, 0, 1, z));
        tbl.push_back(mk(0, 0, 2, 1, 0, 0, z));

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; stall = tbl[i].stall;
            ctx_last = tbl[i].last; iter_cnt = tbl[i].iter;
            model_edge();
            @(posedge CLK); #1;
            check($sformatf("vec%0d", i), 64'(obs()),
                  64'({tbl[i].ebusy, tbl[i].edone, tbl[i].ectx}));
        end
        start = 1'b0; stall = 1'b0;

        // Config lockout and start-while-busy
        ctx_last = 4'd2; iter_cnt = 8'd1; start = 1'b1;
        step("lock_start");
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = {$urandom, $urandom};
        step("lock_write");
        start = 1'b0; cfg_we = 1'b0;
        n = 0;
        while (phase != 0 && n < 20) begin step("lock_run"); n++; end
        step("lock_idle");
        dut_issued = 0;
        run_model(2, 1, 0, 0);
        check("lock_rerun_count", 64'(dut_issued), 64'(3));

        // Abort mid-run, then a fresh full run
        ctx_last = 4'd2; iter_cnt = 8'd4; start = 1'b1;
        step("abort_start");
        start = 1'b0;
        for (int i = 0; i < 2; i++) step("abort_run");
        #2 RST_N = 1'b0;
        #1;
        check("abort_now", 64'(obs()), 64'(0));
        q.delete(); phase = 0;
        @(posedge CLK); #1 RST_N = 1'b1;
        dut_issued = 0;
        run_model(2, 4, 0, 0);
        check("abort_rerun_count", 64'(dut_issued), 64'(12));

        // Randomized runs with stalls and ignored config/start noise
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < DEPTH; a++) load(AW'(a), {$urandom, $urandom});
            run_model($urandom_range(0, DEPTH - 1), $urandom_range(0, 3), 30, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
